// File: rtl/age_issue_queue_pkg.sv
// Shared id/tag widths and the wrap-aware "younger than" test used by every
// flush consumer in the backend (issue queue, ROB, LSQ).
package age_issue_queue_pkg;

  localparam int ID_W   = 7;
  localparam int PREG_W = 6;

  // The MSB of an id is a wrap bit: when the wrap bits differ, the index order is inverted
  function automatic logic younger(input logic [ID_W-1:0] x, input logic [ID_W-1:0] f);
    return (x[ID_W-1] ^ f[ID_W-1]) ^ (x[ID_W-2:0] > f[ID_W-2:0]);
  endfunction

endpackage

// File: rtl/age_issue_queue_if.sv
// Dispatch / wakeup / flush / issue bundle of the issue queue. The master side
// is the backend around the queue; the slave side is the queue itself.
interface age_issue_queue_if #(
  parameter int DATA_WIDTH = 248,
  parameter int PREG_W     = age_issue_queue_pkg::PREG_W,
  parameter int ID_W       = age_issue_queue_pkg::ID_W,
  parameter int WAKE_PORTS = 2,
  parameter int DEPTH_LOG  = 3
);
  logic                         enq_valid;
  logic                         enq_ready;
  logic [DATA_WIDTH-1:0]        enq_data;
  logic [ID_W-1:0]              enq_id;
  logic [PREG_W-1:0]            enq_prs1;
  logic [PREG_W-1:0]            enq_prs2;
  logic                         enq_src1_rdy;
  logic                         enq_src2_rdy;
  logic [WAKE_PORTS-1:0]        wake_valid;
  logic [WAKE_PORTS*PREG_W-1:0] wake_prd;
  logic                         iss_valid;
  logic                         iss_ready;
  logic [DATA_WIDTH-1:0]        iss_data;
  logic [ID_W-1:0]              iss_id;
  logic                         flush_valid;
  logic [ID_W-1:0]              flush_id;
  logic [DEPTH_LOG:0]           count;
  logic                         full;
  logic                         empty;

  modport master (
    output enq_valid, enq_data, enq_id, enq_prs1, enq_prs2, enq_src1_rdy, enq_src2_rdy,
    output wake_valid, wake_prd, iss_ready, flush_valid, flush_id,
    input  enq_ready, iss_valid, iss_data, iss_id, count, full, empty
  );

  modport slave (
    input  enq_valid, enq_data, enq_id, enq_prs1, enq_prs2, enq_src1_rdy, enq_src2_rdy,
    input  wake_valid, wake_prd, iss_ready, flush_valid, flush_id,
    output enq_ready, iss_valid, iss_data, iss_id, count, full, empty
  );

endinterface

// File: rtl/age_issue_queue_age_matrix.sv
// iq_age_matrix: relative-age tracker for the issue queue; returns the one-hot
// oldest entry among the ready mask.
module iq_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DEPTH-1:0] enq_onehot,
  input  logic [DEPTH-1:0] free_mask,
  input  logic [DEPTH-1:0] valid_mask,
  input  logic [DEPTH-1:0] ready_mask,
  output logic [DEPTH-1:0] oldest
);

  // older[i][j] set means entry j was written before entry i
  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_onehot[i])     older[i] <= valid_mask & ~free_mask;
        else if (free_mask[i]) older[i] <= '0;
        else                   older[i] <= older[i] & ~free_mask;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++)
      oldest[i] = ready_mask[i] && ((older[i] & ready_mask) == '0);
  end

endmodule

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue for one execution pipe: wakeup, oldest-ready select,
// registered issue stage and wrap-aware flush. ISSUE_QUEUE_AGE_SELECT_EN enables age-matrix select.
module age_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG  = 3,
  parameter int DATA_WIDTH = 248,
  parameter int PREG_W     = age_issue_queue_pkg::PREG_W,
  parameter int ID_W       = age_issue_queue_pkg::ID_W,
  parameter int WAKE_PORTS = 2
) (
  input logic              clock,
  input logic              reset_n,
  age_issue_queue_if.slave bus
);
  import age_issue_queue_pkg::*;

  logic [DEPTH-1:0]      ent_valid, ent_rdy1, ent_rdy2;
  logic [ID_W-1:0]       ent_id   [DEPTH];
  logic [PREG_W-1:0]     ent_prs1 [DEPTH];
  logic [PREG_W-1:0]     ent_prs2 [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];

  logic                  iss_valid_p1;
  logic [DATA_WIDTH-1:0] iss_data_p1;
  logic [ID_W-1:0]       iss_id_p1;

  logic [DEPTH-1:0]      kill, cand, hit1, hit2, enq_onehot, enq_new, grant, free_mask;
  logic [DEPTH_LOG:0]    occ;
  logic                  full, enq_ready, enq_fire, new_rdy1, new_rdy2;
  logic                  load, sel_fire, iss_kill;
  logic [DATA_WIDTH-1:0] win_data;
  logic [ID_W-1:0]       win_id;

  function automatic logic wake_hit(input logic [PREG_W-1:0] tag,
                                    input logic [WAKE_PORTS-1:0] wv,
                                    input logic [WAKE_PORTS*PREG_W-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++)
      if (wv[k] && wp[k*PREG_W +: PREG_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    kill       = '0;
    cand       = '0;
    hit1       = '0;
    hit2       = '0;
    enq_onehot = '0;
    occ        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = bus.flush_valid && ent_valid[i] && younger(ent_id[i], bus.flush_id);
      cand[i] = ent_valid[i] && ent_rdy1[i] && ent_rdy2[i] && !kill[i];
      hit1[i] = wake_hit(ent_prs1[i], bus.wake_valid, bus.wake_prd);
      hit2[i] = wake_hit(ent_prs2[i], bus.wake_valid, bus.wake_prd);
      occ     = occ + (DEPTH_LOG+1)'(ent_valid[i]);
    end
    // Descending scan so the lowest free index is the one left standing
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        enq_onehot    = '0;
        enq_onehot[i] = 1'b1;
      end
    end
  end

  assign full      = (occ == (DEPTH_LOG+1)'(DEPTH));
  assign enq_ready = !full && !bus.flush_valid;
  assign enq_fire  = bus.enq_valid && enq_ready;
  assign enq_new   = enq_fire ? enq_onehot : '0;
  assign new_rdy1  = bus.enq_src1_rdy || wake_hit(bus.enq_prs1, bus.wake_valid, bus.wake_prd);
  assign new_rdy2  = bus.enq_src2_rdy || wake_hit(bus.enq_prs2, bus.wake_valid, bus.wake_prd);

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  iq_age_matrix #(.DEPTH(DEPTH)) u_age_matrix (
    .clock      (clock),
    .reset_n    (reset_n),
    .enq_onehot (enq_new),
    .free_mask  (free_mask),
    .valid_mask (ent_valid),
    .ready_mask (cand),
    .oldest     (grant)
  );
`else
  assign grant = cand & (~cand + DEPTH'(1));
`endif

  assign load      = !iss_valid_p1 || bus.iss_ready;
  assign sel_fire  = load && (grant != '0);
  assign free_mask = kill | (sel_fire ? grant : '0);
  assign iss_kill  = bus.flush_valid && iss_valid_p1 && younger(iss_id_p1, bus.flush_id);

  always_comb begin
    win_data = '0;
    win_id   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        win_data = ent_data[i];
        win_id   = ent_id[i];
      end
    end
  end

  // Stage p0: entry state (enqueue, wakeup, free on select or flush)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid <= '0;
      ent_rdy1  <= '0;
      ent_rdy2  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_new[i]) begin
          ent_valid[i] <= 1'b1;
          ent_rdy1[i]  <= new_rdy1;
          ent_rdy2[i]  <= new_rdy2;
        end else if (free_mask[i]) begin
          ent_valid[i] <= 1'b0;
          ent_rdy1[i]  <= 1'b0;
          ent_rdy2[i]  <= 1'b0;
        end else if (ent_valid[i]) begin
          ent_rdy1[i]  <= ent_rdy1[i] | hit1[i];
          ent_rdy2[i]  <= ent_rdy2[i] | hit2[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_new[i]) begin
        ent_data[i] <= bus.enq_data;
        ent_id[i]   <= bus.enq_id;
        ent_prs1[i] <= bus.enq_prs1;
        ent_prs2[i] <= bus.enq_prs2;
      end
    end
  end

  // Stage p1: issue register, held while the pipe stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_valid_p1 <= 1'b0;
      iss_data_p1  <= '0;
      iss_id_p1    <= '0;
    end else if (sel_fire) begin
      iss_valid_p1 <= 1'b1;
      iss_data_p1  <= win_data;
      iss_id_p1    <= win_id;
    end else if (load || iss_kill) begin
      iss_valid_p1 <= 1'b0;
    end
  end

  assign bus.enq_ready = enq_ready;
  assign bus.iss_valid = iss_valid_p1;
  assign bus.iss_data  = iss_data_p1;
  assign bus.iss_id    = iss_id_p1;
  assign bus.count     = occ;
  assign bus.full      = full;
  assign bus.empty     = (occ == '0);

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue: reset, issue latency, wakeup, age order,
// backpressure, full, wrap-aware flush and asynchronous reset.
module tb_age_issue_queue;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  localparam logic [6:0] REUSE_FIRST  = 7'h09;
  localparam logic [6:0] REUSE_SECOND = 7'h0A;
`else
  localparam logic [6:0] REUSE_FIRST  = 7'h0A;
  localparam logic [6:0] REUSE_SECOND = 7'h09;
`endif

  always #5 clock = ~clock;

  age_issue_queue_if bus_if ();

  age_issue_queue dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_if.enq_valid    = 1'b0;
    bus_if.enq_data     = '0;
    bus_if.enq_id       = '0;
    bus_if.enq_prs1     = '0;
    bus_if.enq_prs2     = '0;
    bus_if.enq_src1_rdy = 1'b0;
    bus_if.enq_src2_rdy = 1'b0;
    bus_if.wake_valid   = '0;
    bus_if.wake_prd     = '0;
    bus_if.flush_valid  = 1'b0;
    bus_if.flush_id     = '0;
  endtask

  task automatic offer(input logic [6:0] id, input logic [5:0] p1, input logic r1,
                       input logic [247:0] data);
    bus_if.enq_valid    = 1'b1;
    bus_if.enq_id       = id;
    bus_if.enq_prs1     = p1;
    bus_if.enq_prs2     = 6'd1;
    bus_if.enq_src1_rdy = r1;
    bus_if.enq_src2_rdy = 1'b1;
    bus_if.enq_data     = data;
  endtask

  task automatic wake(input int port, input logic [5:0] tag);
    bus_if.wake_valid[port]       = 1'b1;
    bus_if.wake_prd[port*6 +: 6]  = tag;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    idle();
    bus_if.iss_ready = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    bus_if.iss_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_iss_valid", bus_if.iss_valid, 0);
    check("rst_iss_data",  bus_if.iss_data,  0);
    check("rst_iss_id",    bus_if.iss_id,    0);
    check("rst_count",     bus_if.count,     0);
    check("rst_empty",     bus_if.empty,     1);
    check("rst_full",      bus_if.full,      0);
    check("rst_enq_ready", bus_if.enq_ready, 1);
    #2 reset_n = 1'b1;
    tick();

    // Basic issue: one cycle from enqueue to issue register
    offer(7'h03, 6'd2, 1'b1, 248'habc);
    tick(); idle();
    check("basic_count_enq", bus_if.count, 1);
    check("basic_iss_early", bus_if.iss_valid, 0);
    tick();
    check("basic_iss_valid", bus_if.iss_valid, 1);
    check("basic_iss_id",    bus_if.iss_id, 7'h03);
    check("basic_iss_data",  bus_if.iss_data, 248'habc);
    check("basic_count_out", bus_if.count, 0);
    tick();
    check("basic_iss_clear", bus_if.iss_valid, 0);

    // Same-cycle wakeup on port 1 during dispatch
    offer(7'h11, 6'd12, 1'b0, 248'h11);
    wake(1, 6'd12);
    wake(0, 6'd33);
    tick(); idle();
    tick();
    check("wake_same_valid", bus_if.iss_valid, 1);
    check("wake_same_id",    bus_if.iss_id, 7'h11);
    tick();

    // Late wakeup: selectable after the wake edge, issued one edge later
    offer(7'h12, 6'd13, 1'b0, 248'h12);
    tick(); idle();
    tick();
    check("late_wait_valid", bus_if.iss_valid, 0);
    check("late_wait_count", bus_if.count, 1);
    wake(0, 6'd13);
    tick(); idle();
    check("late_wake_edge", bus_if.iss_valid, 0);
    tick();
    check("late_iss_valid", bus_if.iss_valid, 1);
    check("late_iss_id",    bus_if.iss_id, 7'h12);
    check("late_count",     bus_if.count, 0);
    tick();

    // Age order with a shared wakeup tag
    for (int i = 0; i < 3; i++) begin
      offer(7'(5 + i), 6'd9, 1'b0, 248'(5 + i));
      tick();
    end
    idle();
    check("age_count", bus_if.count, 3);
    wake(0, 6'd9);
    tick(); idle();
    tick(); check("age_first",  bus_if.iss_id, 7'h05);
    tick(); check("age_second", bus_if.iss_id, 7'h06);
    tick(); check("age_third",  bus_if.iss_id, 7'h07);
    tick(); check("age_drained", bus_if.iss_valid, 0);

    // Slot reuse: a younger entry lands in the freed lowest slot
    offer(7'h08, 6'd20, 1'b0, 248'h8); tick();
    offer(7'h09, 6'd21, 1'b0, 248'h9); tick(); idle();
    wake(0, 6'd20);
    tick(); idle();
    tick(); check("reuse_x", bus_if.iss_id, 7'h08);
    offer(7'h0A, 6'd21, 1'b0, 248'hA);
    tick(); idle();
    check("reuse_count", bus_if.count, 2);
    wake(1, 6'd21);
    tick(); idle();
    tick(); check("reuse_first",  bus_if.iss_id, REUSE_FIRST);
    tick(); check("reuse_second", bus_if.iss_id, REUSE_SECOND);
    tick();
    check("reuse_drained", bus_if.iss_valid, 0);
    check("reuse_empty",   bus_if.empty, 1);

    // Backpressure: issue register holds while iss_ready is low
    bus_if.iss_ready = 1'b0;
    offer(7'h20, 6'd2, 1'b1, 248'h5555); tick();
    offer(7'h21, 6'd2, 1'b1, 248'h6666); tick(); idle();
    check("bp_loaded", bus_if.iss_id, 7'h20);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_valid", bus_if.iss_valid, 1);
      check("bp_data",  bus_if.iss_data, 248'h5555);
      check("bp_count", bus_if.count, 1);
    end
    for (int i = 0; i < 7; i++) begin
      offer(7'(8'h22 + i), 6'd30, 1'b0, 248'(i));
      tick();
    end
    idle();
    check("fill_count", bus_if.count, 8);
    check("fill_full",  bus_if.full, 1);
    check("fill_empty", bus_if.empty, 0);
    offer(7'h30, 6'd2, 1'b1, 248'h30);
    bus_if.iss_ready = 1'b1;
    #1;
    check("full_enq_ready", bus_if.enq_ready, 0);
    tick(); idle();
    check("full_drop_count", bus_if.count, 7);
    check("full_iss_id",     bus_if.iss_id, 7'h21);
    check("full_ready_back", bus_if.enq_ready, 1);
    do_reset();

    // Wrap-aware flush with a wakeup and an offered entry in the flush cycle
    offer(7'h7E, 6'd40, 1'b0, 248'h7E); tick();
    offer(7'h7F, 6'd40, 1'b0, 248'h7F); tick();
    offer(7'h00, 6'd40, 1'b0, 248'h00); tick();
    offer(7'h01, 6'd40, 1'b0, 248'h01); tick();
    idle();
    check("wrap_count_pre", bus_if.count, 4);
    offer(7'h05, 6'd2, 1'b1, 248'h05);
    wake(0, 6'd40);
    bus_if.flush_valid = 1'b1;
    bus_if.flush_id    = 7'h7F;
    #1;
    check("flush_enq_ready", bus_if.enq_ready, 0);
    tick(); idle();
    check("wrap_count_post", bus_if.count, 2);
    tick(); check("wrap_iss_first",  bus_if.iss_id, 7'h7E);
    tick(); check("wrap_iss_second", bus_if.iss_id, 7'h7F);
    tick();
    check("wrap_drained_valid", bus_if.iss_valid, 0);
    check("wrap_drained_count", bus_if.count, 0);

    // Flush against the issue register: equal id survives, older boundary kills
    bus_if.iss_ready = 1'b0;
    offer(7'h02, 6'd2, 1'b1, 248'h2);
    tick(); idle();
    tick();
    check("issreg_loaded", bus_if.iss_id, 7'h02);
    bus_if.flush_valid = 1'b1;
    bus_if.flush_id    = 7'h02;
    tick(); idle();
    check("flush_eq_keep", bus_if.iss_valid, 1);
    bus_if.flush_valid = 1'b1;
    bus_if.flush_id    = 7'h01;
    tick(); idle();
    check("flush_iss_kill", bus_if.iss_valid, 0);

    // Asynchronous reset between edges with five entries queued
    offer(7'h40, 6'd2, 1'b1, 248'h40);
    tick();
    for (int i = 0; i < 5; i++) begin
      offer(7'(8'h41 + i), 6'd50, 1'b0, 248'(i));
      tick();
    end
    idle();
    check("arst_pre_count", bus_if.count, 5);
    check("arst_pre_iss",   bus_if.iss_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", bus_if.count, 0);
    check("arst_iss",   bus_if.iss_valid, 0);
    check("arst_empty", bus_if.empty, 1);
    check("arst_id",    bus_if.iss_id, 0);
    #3 reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/age_issue_queue.md
# age_issue_queue

Parametrised out-of-order issue queue that sits between dispatch and one execution pipe in the backend. It holds renamed micro-ops until both physical source operands are ready, woken by tag broadcasts from up to WAKE_PORTS writeback ports. It selects the oldest ready entry into a registered issue stage with a valid/ready handshake. It squashes entries younger than a flush instruction id, using wrap-bit id comparison.

## Interface
- DEPTH, 8, number of entries.
- DEPTH_LOG, 3, log2(DEPTH).
- DATA_WIDTH, 248, opaque payload width.
- PREG_W, 6, physical register tag width.
- ID_W, 7, instruction id width: MSB is the wrap bit, the rest is the index.
- WAKE_PORTS, 2, number of wakeup broadcast ports.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- enq_valid  in  1  dispatch offers an entry.
- enq_ready  out  1  queue accepts the entry; equals !full && !flush_valid.
- enq_data  in  DATA_WIDTH  payload.
- enq_id  in  ID_W  instruction id.
- enq_prs1, enq_prs2  in  PREG_W each  source tags.
- enq_src1_rdy, enq_src2_rdy  in  1 each  source already available at dispatch.
- wake_valid  in  WAKE_PORTS  per-port broadcast valid.
- wake_prd  in  WAKE_PORTS*PREG_W  broadcast tags; port k occupies bits [k*PREG_W +: PREG_W].
- iss_valid  out  1  issue register holds an entry.
- iss_ready  in  1  execution pipe accepts.
- iss_data  out  DATA_WIDTH  issued payload.
- iss_id  out  ID_W  issued id.
- flush_valid  in  1  squash request.
- flush_id  in  ID_W  squash boundary.
- count  out  DEPTH_LOG+1  occupied entries, excluding the issue register.
- full, empty  out  1 each  count==DEPTH, count==0.

## Operation
- Each entry holds: valid, data, id, prs1, prs2, rdy1, rdy2.
- **Enqueue.** An entry is written on an enq_valid && enq_ready edge into the lowest-index free slot.
  - Stored rdy1 = enq_src1_rdy OR a match of enq_prs1 against any valid wake port in the same cycle; rdy2 likewise.
- **Wakeup.** For every valid entry, any wake port with wake_valid[k] whose tag equals prs1 (prs2) sets rdy1 (rdy2). Multiple ports may hit the same entry; the result is an OR.
- **Select.** Candidates are entries with valid && rdy1 && rdy2 && not killed by this cycle's flush. The winner is the oldest by age order.
- **Issue register.**
  - It loads the winner when it is empty or iss_ready=1.
  - The winning slot is freed on that same edge.
  - If there is no winner and iss_ready=1, iss_valid clears.
  - iss_data and iss_id hold stable while iss_valid && !iss_ready.
- **Flush.** Younger(x,f) = (x[ID_W-1]^f[ID_W-1]) ^ (x[ID_W-2:0] > f[ID_W-2:0]).
  - On flush_valid, every queue entry with Younger(id, flush_id) is invalidated, and so is the issue register if Younger(iss_id, flush_id).
  - An entry whose id equals flush_id survives.
- count updates by +enq −select −flushed in one edge.
- A slot freed on an edge is reusable on the next edge, not the same edge.

## Timing
- Reset values: iss_valid=0, iss_data=0, iss_id=0, count=0, empty=1, full=0, enq_ready=1, all entry valid and rdy bits 0.
- Minimum latency: enqueue at edge N with both sources ready, selected at edge N+1, iss_valid=1 in cycle N+1.
- A wakeup at edge N makes the entry selectable in cycle N; it loads at edge N+1.
- Back-to-back issue of one entry per cycle is sustained while iss_ready=1 and candidates exist.
- **Full:** enq_ready=0 even if an entry leaves that cycle.
- **Flush cycle:** enq_ready=0 and the offered entry is dropped. A wakeup landing on a killed entry has no effect. A killed entry is never selected.
- reset_n asserted mid-operation clears all state immediately, regardless of clock.

## Configuration
- Macro: ISSUE_QUEUE_AGE_SELECT_EN.
- **Defined:** a DEPTH×DEPTH age matrix is built. On enqueue, row[new] is set to all other valid entries (they are older). Freed entries' bits are cleared. Select returns the oldest ready entry.
- **Undefined:** there is no age matrix and select is a fixed lowest-index-first priority. Functional behaviour is otherwise identical; only the ordering among simultaneous ready entries differs.

## Structure
- Shared package: ID_W, PREG_W, and the Younger() comparison function, reused by ROB and LSQ flush logic.
- One sub-module: iq_age_matrix. Inputs are enqueue one-hot, free mask and ready mask; output is the one-hot oldest ready. It is instantiated only under ISSUE_QUEUE_AGE_SELECT_EN.

## Test plan
- **Basic issue:** enqueue id=3 with both sources ready, iss_ready=1 → iss_valid=1 one cycle later with iss_id=3; count returns to 0.
- **Same-cycle wake:** enqueue prs1=12 not ready while wake_prd port1=12 in the same cycle → entry issues exactly as if it were ready at dispatch.
- **Age order:** enqueue ids 5, 6, 7 all waiting on tag 9, then wake tag 9 → issue order 5, 6, 7 with the macro defined. Repeat after frees to verify reuse of lower slots does not reorder.
- **Backpressure:** hold iss_ready=0 for 4 cycles with a ready entry → iss_data stable, iss_valid=1, count unchanged; fill to DEPTH=8 → full=1, enq_ready=0.
- **Wrap flush:** entries with ids 0x7E, 0x7F, 0x00, 0x01 and flush_id=0x7F → 0x00 and 0x01 are removed, count=2; enqueue offered in the flush cycle is dropped.
- **Async reset:** drop reset_n between edges with 5 entries present → count=0 and iss_valid=0 immediately.
